// File: rtl/uart_packet_parser.sv
// Frames UART bytes into SYNC/CMD/LEN/payload/CHK packets, checks the XOR checksum
// and holds each good packet, with its payload in a small RAM, until the consumer acks.
module uart_packet_parser #(
   parameter int         MAX_LEN        = 64,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 50000,
   parameter int         AW             = $clog2(MAX_LEN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic          pkt_valid,
   output logic [7:0]    pkt_cmd,
   output logic [7:0]    pkt_len,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   input  logic          pkt_ack,
   output logic          err_chk,
   output logic          err_len,
   output logic          err_timeout,
   output logic          err_drop,
   output logic [15:0]   err_count
);

   localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CMD     = 3'd1;
   localparam logic [2:0] S_LEN     = 3'd2;
   localparam logic [2:0] S_PAYLOAD = 3'd3;
   localparam logic [2:0] S_CHK     = 3'd4;
   localparam logic [2:0] S_HOLD    = 3'd5;

   logic [2:0]    r_state;
   logic [7:0]    r_pkt_cmd;
   logic [7:0]    r_pkt_len;
   logic [7:0]    r_chk;
   logic [7:0]    r_idx;
   logic [TW-1:0] r_tmo;
   logic          r_err_chk;
   logic          r_err_len;
   logic          r_err_timeout;
   logic          r_err_drop;
   logic [15:0]   r_err_count;
   logic [7:0]    r_rd_data;
   logic [7:0]    r_buf [0:MAX_LEN-1];

   logic [2:0]    w_state_next;
   logic [7:0]    w_cmd_next;
   logic [7:0]    w_len_next;
   logic [7:0]    w_chk_next;
   logic [7:0]    w_idx_next;
   logic [TW-1:0] w_tmo_next;
   logic          w_err_chk;
   logic          w_err_len;
   logic          w_err_timeout;
   logic          w_err_drop;
   logic          w_wr_en;
   logic          w_active;
   logic          w_any_err;

   assign w_active = (r_state == S_CMD) || (r_state == S_LEN) ||
                     (r_state == S_PAYLOAD) || (r_state == S_CHK);
   assign w_any_err = w_err_chk | w_err_len | w_err_timeout | w_err_drop;

   always_comb begin
      w_state_next  = r_state;
      w_cmd_next    = r_pkt_cmd;
      w_len_next    = r_pkt_len;
      w_chk_next    = r_chk;
      w_idx_next    = r_idx;
      w_tmo_next    = '0;
      w_err_chk     = 1'b0;
      w_err_len     = 1'b0;
      w_err_timeout = 1'b0;
      w_err_drop    = 1'b0;
      w_wr_en       = 1'b0;

      // A byte arriving on the expiry cycle takes priority over the timeout.
      if (w_active && !rx_valid) begin
         if (r_tmo == TMO_LAST) begin
            w_err_timeout = 1'b1;
            w_state_next  = S_IDLE;
         end else begin
            w_tmo_next = r_tmo + TW'(1);
         end
      end

      case (r_state)
         S_IDLE: begin
            if (rx_valid && rx_data == SYNC_BYTE)
               w_state_next = S_CMD;
         end
         S_CMD: begin
            if (rx_valid) begin
               w_cmd_next   = rx_data;
               w_chk_next   = rx_data;
               w_state_next = S_LEN;
            end
         end
         S_LEN: begin
            if (rx_valid) begin
               if (rx_data > MAX_LEN_B) begin
                  w_err_len    = 1'b1;
                  w_state_next = S_IDLE;
               end else begin
                  w_len_next   = rx_data;
                  w_chk_next   = r_chk ^ rx_data;
                  w_idx_next   = 8'd0;
                  w_state_next = (rx_data == 8'd0) ? S_CHK : S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (rx_valid) begin
               w_wr_en    = 1'b1;
               w_chk_next = r_chk ^ rx_data;
               w_idx_next = r_idx + 8'd1;
               if (r_idx == r_pkt_len - 8'd1)
                  w_state_next = S_CHK;
            end
         end
         S_CHK: begin
            if (rx_valid) begin
               if (rx_data == r_chk) begin
                  w_state_next = S_HOLD;
               end else begin
                  w_err_chk    = 1'b1;
                  w_state_next = S_IDLE;
               end
            end
         end
         S_HOLD: begin
            if (rx_valid)
               w_err_drop = 1'b1;
            if (pkt_ack)
               w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_pkt_cmd     <= 8'd0;
         r_pkt_len     <= 8'd0;
         r_chk         <= 8'd0;
         r_idx         <= 8'd0;
         r_tmo         <= '0;
         r_err_chk     <= 1'b0;
         r_err_len     <= 1'b0;
         r_err_timeout <= 1'b0;
         r_err_drop    <= 1'b0;
         r_err_count   <= 16'd0;
      end else begin
         r_state       <= w_state_next;
         r_pkt_cmd     <= w_cmd_next;
         r_pkt_len     <= w_len_next;
         r_chk         <= w_chk_next;
         r_idx         <= w_idx_next;
         r_tmo         <= w_tmo_next;
         r_err_chk     <= w_err_chk;
         r_err_len     <= w_err_len;
         r_err_timeout <= w_err_timeout;
         r_err_drop    <= w_err_drop;
         if (w_any_err && r_err_count != 16'hFFFF)
            r_err_count <= r_err_count + 16'd1;
      end
   end

   // Payload RAM: no reset on the array so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (w_wr_en)
         r_buf[r_idx[AW-1:0]] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_rd_data <= 8'd0;
      else
         r_rd_data <= r_buf[rd_addr];
   end

   assign pkt_valid   = (r_state == S_HOLD);
   assign pkt_cmd     = r_pkt_cmd;
   assign pkt_len     = r_pkt_len;
   assign rd_data     = r_rd_data;
   assign err_chk     = r_err_chk;
   assign err_len     = r_err_len;
   assign err_timeout = r_err_timeout;
   assign err_drop    = r_err_drop;
   assign err_count   = r_err_count;

endmodule

// File: tb/tb_uart_packet_parser.sv
// Directed bench for uart_packet_parser: expected packets and error pulses are queued
// as stimulus is driven and consumed when the parser presents them.
module tb_uart_packet_parser;

   localparam int T = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        pkt_valid;
   logic [7:0]  pkt_cmd;
   logic [7:0]  pkt_len;
   logic [5:0]  rd_addr;
   logic [7:0]  rd_data;
   logic        pkt_ack;
   logic        err_chk;
   logic        err_len;
   logic        err_timeout;
   logic        err_drop;
   logic [15:0] err_count;

   always #10 clk = ~clk;

   uart_packet_parser #(
      .MAX_LEN(64), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T), .AW(6)
   ) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .pkt_valid(pkt_valid), .pkt_cmd(pkt_cmd), .pkt_len(pkt_len),
      .rd_addr(rd_addr), .rd_data(rd_data), .pkt_ack(pkt_ack),
      .err_chk(err_chk), .err_len(err_len), .err_timeout(err_timeout),
      .err_drop(err_drop), .err_count(err_count)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          exp_total = 0;
   logic [3:0]  exp_err_q [$];
   logic [15:0] exp_hdr_q [$];
   logic [7:0]  exp_byte_q [$];
   logic [7:0]  pl [64];
   logic [7:0]  cur_pl [64];
   logic [7:0]  cur_cmd;
   logic [7:0]  cur_len;

   localparam logic [3:0] E_CHK = 4'b0001;
   localparam logic [3:0] E_LEN = 4'b0010;
   localparam logic [3:0] E_TMO = 4'b0100;
   localparam logic [3:0] E_DRP = 4'b1000;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Every error pulse must match the next queued expectation.
   always @(negedge clk) begin
      if (!rst && (err_chk || err_len || err_timeout || err_drop)) begin
         if (exp_err_q.size() == 0)
            check("unexpected_err", {12'd0, err_drop, err_timeout, err_len, err_chk}, 16'd0);
         else
            check("err_kind", {12'd0, err_drop, err_timeout, err_len, err_chk},
                  {12'd0, exp_err_q.pop_front()});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic expect_err(input logic [3:0] e);
      exp_err_q.push_back(e);
      exp_total++;
   endtask

   task automatic send_pkt(input logic [7:0] cmd, input int len, input logic [7:0] bad);
      logic [7:0] c;
      c = cmd ^ 8'(len);
      for (int i = 0; i < len; i++) c = c ^ pl[i];
      if (bad == 8'd0) begin
         exp_hdr_q.push_back({cmd, 8'(len)});
         for (int i = 0; i < len; i++) exp_byte_q.push_back(pl[i]);
      end else begin
         expect_err(E_CHK);
      end
      send_byte(8'hA5);
      send_byte(cmd);
      send_byte(8'(len));
      for (int i = 0; i < len; i++) send_byte(pl[i]);
      send_byte(c ^ bad);
   endtask

   task automatic read_payload();
      for (int i = 0; i < int'(cur_len); i++) begin
         rd_addr = 6'(i);
         @(posedge clk);
         #1;
         check("rd_data", {8'd0, rd_data}, {8'd0, cur_pl[i]});
      end
   endtask

   // Called right after the CHK byte edge: the packet must already be presented.
   task automatic take_pkt();
      logic [15:0] h;
      check("pkt_valid_rise", {15'd0, pkt_valid}, 16'd1);
      check("hdr_q_nonempty", {15'd0, exp_hdr_q.size() != 0}, 16'd1);
      if (exp_hdr_q.size() != 0) begin
         h       = exp_hdr_q.pop_front();
         cur_cmd = h[15:8];
         cur_len = h[7:0];
         for (int i = 0; i < int'(cur_len); i++)
            cur_pl[i] = (exp_byte_q.size() != 0) ? exp_byte_q.pop_front() : 8'hXX;
         check("pkt_cmd", {8'd0, pkt_cmd}, {8'd0, cur_cmd});
         check("pkt_len", {8'd0, pkt_len}, {8'd0, cur_len});
         read_payload();
      end
   endtask

   task automatic ack();
      pkt_ack = 1'b1;
      @(posedge clk);
      #1;
      pkt_ack = 1'b0;
      check("pkt_valid_after_ack", {15'd0, pkt_valid}, 16'd0);
   endtask

   task automatic checkpoint();
      idle(2);
      check("err_q_drained", 16'(exp_err_q.size()), 16'd0);
      check("err_count", err_count, 16'(exp_total));
   endtask

   task automatic check_reset_outputs();
      check("rst_pkt_valid", {15'd0, pkt_valid}, 16'd0);
      check("rst_pkt_cmd", {8'd0, pkt_cmd}, 16'd0);
      check("rst_pkt_len", {8'd0, pkt_len}, 16'd0);
      check("rst_rd_data", {8'd0, rd_data}, 16'd0);
      check("rst_err_pulses", {12'd0, err_drop, err_timeout, err_len, err_chk}, 16'd0);
      check("rst_err_count", err_count, 16'd0);
   endtask

   initial begin
      rst = 1'b1; rx_data = 8'd0; rx_valid = 1'b0; pkt_ack = 1'b0; rd_addr = 6'd0;
      idle(3);
      check_reset_outputs();
      rst = 1'b0;
      idle(1);

      // Good packet, then a dropped byte while held.
      pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
      send_pkt(8'h10, 3, 8'h00);
      take_pkt();
      checkpoint();
      expect_err(E_DRP);
      send_byte(8'h55);
      check("pkt_valid_during_drop", {15'd0, pkt_valid}, 16'd1);
      read_payload();
      checkpoint();
      ack();
      checkpoint();

      // Garbage prefix then bad checksum.
      send_byte(8'h00);
      send_byte(8'hFF);
      send_pkt(8'h10, 3, 8'h07);
      check("bad_chk_no_valid", {15'd0, pkt_valid}, 16'd0);
      checkpoint();

      // Zero length packet.
      send_pkt(8'h07, 0, 8'h00);
      take_pkt();
      ack();
      checkpoint();

      // Length overflow, then a good packet straight after.
      expect_err(E_LEN);
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h41);
      pl[0] = 8'hAB; pl[1] = 8'hCD;
      send_pkt(8'h22, 2, 8'h00);
      take_pkt();
      ack();
      checkpoint();

      // Maximum length packet.
      for (int i = 0; i < 64; i++) pl[i] = 8'(i * 7 + 3);
      send_pkt(8'h5A, 64, 8'h00);
      take_pkt();
      ack();
      checkpoint();

      // Timeout after exactly T idle clocks.
      send_byte(8'hA5);
      send_byte(8'h10);
      idle(T - 1);
      check("tmo_not_early", {15'd0, err_timeout}, 16'd0);
      expect_err(E_TMO);
      idle(1);
      check("tmo_pulse", {15'd0, err_timeout}, 16'd1);
      idle(1);
      check("tmo_width", {15'd0, err_timeout}, 16'd0);
      check("tmo_no_valid", {15'd0, pkt_valid}, 16'd0);
      checkpoint();

      // A byte on the expiry cycle suppresses the timeout.
      send_byte(8'hA5);
      send_byte(8'h10);
      idle(T - 1);
      exp_hdr_q.push_back({8'h10, 8'h00});
      send_byte(8'h00);
      check("tmo_suppressed", {15'd0, err_timeout}, 16'd0);
      idle(T - 2);
      send_byte(8'h10);
      take_pkt();
      ack();
      checkpoint();

      // Ack colliding with a byte in HOLD, then SYNC on the very next cycle.
      pl[0] = 8'h01; pl[1] = 8'h02;
      send_pkt(8'h44, 2, 8'h00);
      take_pkt();
      expect_err(E_DRP);
      pkt_ack = 1'b1; rx_data = 8'h77; rx_valid = 1'b1;
      @(posedge clk);
      #1;
      pkt_ack = 1'b0; rx_valid = 1'b0;
      check("collide_valid_low", {15'd0, pkt_valid}, 16'd0);
      pl[0] = 8'h05; pl[1] = 8'h06; pl[2] = 8'h07;
      send_pkt(8'h66, 3, 8'h00);
      take_pkt();
      ack();
      checkpoint();

      // Reset in the middle of a payload.
      send_byte(8'hA5);
      send_byte(8'h10);
      send_byte(8'h05);
      send_byte(8'h01);
      send_byte(8'h02);
      rst = 1'b1;
      idle(1);
      check_reset_outputs();
      rst = 1'b0;
      exp_total = 0;
      exp_err_q.delete();
      idle(1);
      pl[0] = 8'h9A;
      send_pkt(8'h3C, 1, 8'h00);
      take_pkt();
      ack();
      checkpoint();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_packet_parser.md
# uart_packet_parser

Byte-to-packet framing stage that sits directly downstream of the UART receiver. It consumes the receiver's `rx_data`/`rx_valid` byte strobe and locates packets of the form SYNC, CMD, LEN, LEN payload bytes, CHK. It verifies length and checksum, buffers the payload, and presents each good packet to the command/vision logic until that logic acknowledges it. Bad or stalled packets are discarded and reported as error pulses and a counter.

## Interface
- `MAX_LEN`, 64: maximum payload bytes; also the buffer depth.
- `SYNC_BYTE`, 8'hA5: packet start marker.
- `TIMEOUT_CYCLES`, 50000: maximum idle clocks between bytes inside a packet (about 11.5 byte times at 115200 baud / 50 MHz).
- `AW`, `$clog2(MAX_LEN)`: buffer address width.

Ports:
- `clk`  in  1: system clock, 50 MHz. One clock; reset is synchronous and active-high.
- `rst`  in  1: synchronous, active-high reset.
- `rx_data`  in  8: received byte from the UART receiver.
- `rx_valid`  in  1: one-cycle strobe; `rx_data` is valid in that cycle.
- `pkt_valid`  out  1: a good packet is held; level signal.
- `pkt_cmd`  out  8: CMD byte of the held packet.
- `pkt_len`  out  8: LEN byte of the held packet.
- `rd_addr`  in  AW: payload read address.
- `rd_data`  out  8: payload byte at `rd_addr`, registered.
- `pkt_ack`  in  1: consumer releases the held packet.
- `err_chk`, `err_len`, `err_timeout`, `err_drop`  out  1 each: one-cycle error pulses.
- `err_count`  out  16: saturating total of all error pulses.

## Operation
- States:
  - IDLE: on an `rx_valid` byte equal to SYNC_BYTE, go to CMD. Any other byte is ignored silently (no error).
  - CMD: capture `pkt_cmd`, set chk = byte, go to LEN.
  - LEN:
    - If byte > MAX_LEN: pulse `err_len`, go to IDLE.
    - Else: capture `pkt_len`, chk ^= byte, clear the write index.
    - If byte == 0, go to CHK; otherwise go to PAYLOAD.
  - PAYLOAD: write the byte to `buf[idx]`, chk ^= byte, idx++. After the LEN-th byte, go to CHK.
  - CHK: if byte == chk, go to HOLD. Otherwise pulse `err_chk` and go to IDLE.
  - HOLD: `pkt_valid` = 1.
    - Any `rx_valid` byte is discarded and pulses `err_drop`.
    - `pkt_ack` = 1 moves to IDLE.
- Checksum is an 8-bit XOR over CMD, LEN and all payload bytes. SYNC and CHK are excluded.
- Timeout counter:
  - Cleared on every `rx_valid` and in IDLE/HOLD.
  - Increments in CMD, LEN, PAYLOAD and CHK.
  - On reaching TIMEOUT_CYCLES−1 without `rx_valid`: pulse `err_timeout`, go to IDLE.
- `err_count` increments by 1 per error pulse and saturates at 16'hFFFF. Only one error can fire per cycle.
- `pkt_cmd`/`pkt_len` are only written in CMD/LEN. They are stable for the whole of HOLD.
- The payload buffer is a single-port-write, single-port-read RAM (inferred). Contents are not cleared by reset.
- Reading is only meaningful in HOLD with `rd_addr` < `pkt_len`. Other reads return don't-care data.

## Timing
- Reset values: state IDLE; `pkt_valid`=0; `pkt_cmd`=0; `pkt_len`=0; `rd_data`=0; all error pulses 0; `err_count`=0; timeout counter 0.
- Reset asserted mid-packet aborts the packet with no error pulse.
- Every byte is consumed in its `rx_valid` cycle. The state changes on the following edge.
- `pkt_valid` rises on the clock edge after the `rx_valid` cycle carrying a correct CHK byte.
- `pkt_ack` sampled high in HOLD: `pkt_valid` is 0 from the next cycle. A new SYNC is accepted from the cycle after that.
- `pkt_ack` outside HOLD is ignored.
- `pkt_ack` and `rx_valid` in the same HOLD cycle: the byte is dropped (`err_drop`=1) and the state goes to IDLE.
- `rx_valid` and timeout expiry in the same cycle: the byte wins. It is consumed, the counter clears, and there is no `err_timeout`.
- `rd_data` = `buf[rd_addr]` one cycle after `rd_addr` is presented (1-cycle latency). Back-to-back addresses give one byte per cycle.
- Error pulses are exactly 1 cycle wide, asserted the cycle after the offending byte or the timeout expiry.
- The consumer may hold the packet indefinitely. Upstream has no backpressure, so all bytes arriving during HOLD are lost and counted.

## Test plan
- **Good packet:** bytes A5 10 03 11 22 33 13 → `pkt_valid`=1, `pkt_cmd`=10, `pkt_len`=03. Reads of addr 0,1,2 return 11,22,33 one cycle later. `pkt_ack` → `pkt_valid`=0 next cycle; `err_count`=0.
- **Bad checksum and garbage prefix:** 00 FF A5 10 03 11 22 33 14 → `err_chk` pulse, `pkt_valid` stays 0, `err_count`=1. The leading 00 FF produce no error.
- **Zero length:** A5 07 00 07 → `pkt_valid`=1, `pkt_cmd`=07, `pkt_len`=00.
- **Length overflow then recovery:** A5 01 41 → `err_len`. A good packet sent immediately after is accepted.
- **Timeout:** A5 10 then no bytes → `err_timeout` after TIMEOUT_CYCLES idle clocks. A byte arriving exactly on the expiry cycle suppresses the timeout.
- **Drop, ack collision and reset:**
  - Good packet held, send 55 → `err_drop`, payload unchanged.
  - `pkt_ack` coincident with `rx_valid` → drop counted and state IDLE.
  - `rst` mid-PAYLOAD → IDLE, outputs at reset values, `err_count`=0.
